key_click_decoder: RTL and testbench
====================================

Name: key_click_decoder

Overview:
- Consumes the active-low, one-cycle key-press strobe from the key debouncer and groups presses into click bursts (single, double, triple, ...).
- A burst closes once no new press arrives within a programmable window. The block then reports the press count with a one-cycle valid pulse.
- Sits between the debouncer and the UI/control logic, e.g. mode select by double-click.

Parameters:
- WINDOW_CYCLES, 15_000_000, inter-press window in i_clk cycles (300 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 24, width of the window timer.
- CLICK_W, 3, width of o_click_cnt; count saturates at 2^CLICK_W-1.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_key_n  input  1  debounced key-press strobe, 0 = press, idle 1.
- i_clr  input  1  synchronous abort; discards any burst in progress.
- o_click_valid  output  1  one-cycle high pulse: burst finished.
- o_click_cnt  output  CLICK_W  number of presses in burst; held until next report.
- o_click_sat  output  1  burst exceeded 2^CLICK_W-1 presses; held with o_click_cnt.
- o_busy  output  1  high while a burst is being collected.

Behaviour:
- Reset i_rst_n, asynchronous, active-low; clock i_clk.
- Reset values:
  - state IDLE
  - key_prev=1, timer=0, clicks=0
  - o_click_valid=0, o_click_cnt=0, o_click_sat=0, o_busy=0
- Press detection:
  - press = key_prev & ~i_key_n, where key_prev is i_key_n registered every cycle.
  - i_key_n held low for N cycles counts as one press.
  - No extra sampling latency: the press acts at the edge where i_key_n is first sampled 0.
- IDLE (o_busy=0):
  - On press: clicks<=1, sat<=0, timer<=0, go to COLLECT.
  - Otherwise hold.
- COLLECT (o_busy=1), priority order:
  - i_clr: go to IDLE, clicks<=0, no report.
  - press: timer<=0. If clicks is at max, set sat; else clicks<=clicks+1.
  - timer==WINDOW_CYCLES-1: go to IDLE; o_click_valid<=1, o_click_cnt<=clicks, o_click_sat<=sat.
  - else: timer<=timer+1.
- Latency: with the last press acted on at edge E and no further press, o_click_valid is high for exactly the one cycle following edge E+WINDOW_CYCLES.
- o_click_valid is registered and self-clearing; it is 0 in every cycle except the report cycle.
- o_busy is registered; it is high from the cycle after the first press edge through the cycle before o_click_valid.
- Simultaneous events:
  - Press on the expiry edge: the press wins. It is counted, the timer restarts, and there is no report.
  - Press during the report cycle: acted on from IDLE, starting a new burst with clicks=1. The report is unaffected.
  - i_clr together with press: i_clr wins and the press is discarded. i_clr in IDLE has no effect.
- Width/arithmetic:
  - The timer never wraps; it is compared against WINDOW_CYCLES-1 only.
  - The clicks counter saturates and never wraps.
- Reset mid-burst: everything returns to reset values immediately; no report.

Test Plan:
- WINDOW_CYCLES=16. One 1-cycle low pulse on i_key_n at edge E -> o_busy=1 from E+1; o_click_valid=1 with o_click_cnt=1, o_click_sat=0 only in the cycle after E+16; o_busy=0 in that cycle.
- Two pulses 10 cycles apart -> single report, o_click_cnt=2, 16 cycles after the second press edge. Pulses 17 cycles apart -> two reports, each cnt=1.
- Eight presses 5 cycles apart (CLICK_W=3) -> one report, o_click_cnt=7, o_click_sat=1.
- i_key_n held low 40 cycles -> counted as one press; report cnt=1 16 cycles after the falling-edge sample.
- Press coincident with the expiry edge -> no report; report cnt=2 16 cycles later. Press in the report cycle -> report cnt=1 plus a new burst with o_busy=1.
- i_clr after 2 presses -> o_busy=0 next cycle, no o_click_valid; previous o_click_cnt retained. Assert i_rst_n low mid-burst -> all outputs 0 asynchronously, no report after release.

Source files
------------

// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - groups debounced key presses into click bursts and reports the count
module key_click_decoder #(
    parameter int WINDOW_CYCLES = 15_000_000,
    parameter int CNT_W         = 24,
    parameter int CLICK_W       = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_key_n,
    input  logic               i_clr,
    output logic               o_click_valid,
    output logic [CLICK_W-1:0] o_click_cnt,
    output logic               o_click_sat,
    output logic               o_busy
);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    localparam logic [CNT_W-1:0]   TIMER_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CLICK_W-1:0] CLICK_MAX  = '1;

    state_t               state_q, state_d;
    logic                 key_prev_q, key_prev_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [CLICK_W-1:0]   clicks_q, clicks_d;
    logic                 sat_q, sat_d;
    logic                 click_valid_q, click_valid_d;
    logic [CLICK_W-1:0]   click_cnt_q, click_cnt_d;
    logic                 click_sat_q, click_sat_d;
    logic                 busy_q, busy_d;
    logic                 press;

    // A press is the first cycle the strobe is seen low; holding it low adds nothing.
    assign press = key_prev_q & ~i_key_n;

    // Next-state logic: collect presses until the window expires, then report once.
    always_comb begin
        state_d       = state_q;
        key_prev_d    = i_key_n;
        timer_d       = timer_q;
        clicks_d      = clicks_q;
        sat_d         = sat_q;
        click_valid_d = 1'b0;
        click_cnt_d   = click_cnt_q;
        click_sat_d   = click_sat_q;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d  = S_COLLECT;
                    clicks_d = CLICK_W'(1);
                    sat_d    = 1'b0;
                    timer_d  = '0;
                end
            end
            S_COLLECT: begin
                if (i_clr) begin
                    state_d  = S_IDLE;
                    clicks_d = '0;
                end else if (press) begin
                    // A press on the expiry edge still wins and restarts the window.
                    timer_d = '0;
                    if (clicks_q == CLICK_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        clicks_d = clicks_q + CLICK_W'(1);
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d       = S_IDLE;
                    click_valid_d = 1'b1;
                    click_cnt_d   = clicks_q;
                    click_sat_d   = sat_q;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_COLLECT);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            key_prev_q    <= 1'b1;
            timer_q       <= '0;
            clicks_q      <= '0;
            sat_q         <= 1'b0;
            click_valid_q <= 1'b0;
            click_cnt_q   <= '0;
            click_sat_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_prev_q    <= key_prev_d;
            timer_q       <= timer_d;
            clicks_q      <= clicks_d;
            sat_q         <= sat_d;
            click_valid_q <= click_valid_d;
            click_cnt_q   <= click_cnt_d;
            click_sat_q   <= click_sat_d;
            busy_q        <= busy_d;
        end
    end

    assign o_click_valid = click_valid_q;
    assign o_click_cnt   = click_cnt_q;
    assign o_click_sat   = click_sat_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// tb/tb_key_click_decoder.sv - self-checking bench for key_click_decoder
module tb_key_click_decoder;

    localparam int W       = 16;
    localparam int CNT_W   = 8;
    localparam int CLICK_W = 3;
    localparam int MAXC    = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               key_n;
    logic               clr;
    logic               click_valid;
    logic [CLICK_W-1:0] click_cnt;
    logic               click_sat;
    logic               busy;

    always #5 clk = ~clk;

    key_click_decoder #(
        .WINDOW_CYCLES(W),
        .CNT_W        (CNT_W),
        .CLICK_W      (CLICK_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_n      (key_n),
        .i_clr        (clr),
        .o_click_valid(click_valid),
        .o_click_cnt  (click_cnt),
        .o_click_sat  (click_sat),
        .o_busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a burst is open while the last press is less than W edges old.
    int cyc = 0;
    bit m_active;
    int m_cnt;
    bit m_sat;
    int m_last;
    bit m_prev;
    bit m_valid;
    int m_rcnt;
    bit m_rsat;

    int nvalid = 0;
    int vcyc   = -1;

    task automatic model_reset();
        m_active = 0; m_cnt = 0; m_sat = 0; m_last = 0;
        m_prev = 1; m_valid = 0; m_rcnt = 0; m_rsat = 0;
    endtask

    task automatic model_edge();
        bit press;
        m_valid = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            press  = m_prev && !key_n;
            m_prev = key_n;
            if (m_active && clr) begin
                m_active = 0;
            end else if (press) begin
                if (!m_active) begin
                    m_active = 1; m_cnt = 1; m_sat = 0;
                end else if (m_cnt == MAXC) begin
                    m_sat = 1;
                end else begin
                    m_cnt++;
                end
                m_last = cyc;
            end else if (m_active && (cyc - m_last == W)) begin
                m_active = 0;
                m_valid  = 1;
                m_rcnt   = m_cnt;
                m_rsat   = m_sat;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("valid", click_valid, m_valid);
        chk("cnt",   click_cnt,   m_rcnt);
        chk("sat",   click_sat,   m_rsat);
        chk("busy",  busy,        m_active);
        if (click_valid === 1'b1) begin
            nvalid++;
            vcyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press_pulse();
        key_n = 1'b0;
        step();
        key_n = 1'b1;
    endtask

    int e1, e2, nv0, rate;

    initial begin
        rst_n = 1'b0; key_n = 1'b1; clr = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        chk("rst_valid", click_valid, 0);
        chk("rst_cnt",   click_cnt,   0);
        chk("rst_sat",   click_sat,   0);
        chk("rst_busy",  busy,        0);
        idle(3);

        // Single press: report exactly W edges after the press edge.
        e1 = cyc + 1; nv0 = nvalid;
        press_pulse();
        chk("single_busy", busy, 1);
        idle(20);
        chk("single_lat", vcyc - e1, W);
        chk("single_n",   nvalid - nv0, 1);
        chk("single_cnt", click_cnt, 1);

        // Two presses 10 apart: one report, cnt 2.
        e1 = cyc + 1; nv0 = nvalid;
        press_pulse(); idle(9);
        e2 = cyc + 1;
        press_pulse(); idle(20);
        chk("dbl_n",   nvalid - nv0, 1);
        chk("dbl_lat", vcyc - e2, W);
        chk("dbl_cnt", click_cnt, 2);

        // Presses 17 apart: second lands in the report cycle.
        nv0 = nvalid;
        press_pulse(); idle(16);
        press_pulse();
        chk("rep_press_busy", busy, 1);
        chk("rep_press_n",    nvalid - nv0, 1);
        idle(20);
        chk("sep_n",   nvalid - nv0, 2);
        chk("sep_cnt", click_cnt, 1);

        // Eight presses saturate the 3-bit count.
        nv0 = nvalid;
        repeat (8) begin
            press_pulse(); idle(4);
        end
        idle(20);
        chk("sat_n",   nvalid - nv0, 1);
        chk("sat_cnt", click_cnt, 7);
        chk("sat_flag", click_sat, 1);

        // Key held low 40 cycles counts once.
        e1 = cyc + 1; nv0 = nvalid;
        key_n = 1'b0;
        idle(40);
        key_n = 1'b1;
        idle(10);
        chk("hold_n",   nvalid - nv0, 1);
        chk("hold_lat", vcyc - e1, W);
        chk("hold_cnt", click_cnt, 1);

        // Press on the expiry edge wins.
        nv0 = nvalid;
        press_pulse(); idle(15);
        e2 = cyc + 1;
        press_pulse(); idle(20);
        chk("exp_n",   nvalid - nv0, 1);
        chk("exp_lat", vcyc - e2, W);
        chk("exp_cnt", click_cnt, 2);

        // Clear after two presses: no report, previous count kept.
        nv0 = nvalid;
        press_pulse(); idle(3);
        press_pulse(); idle(3);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_busy", busy, 0);
        idle(25);
        chk("clr_n",   nvalid - nv0, 0);
        chk("clr_cnt", click_cnt, 2);

        // Reset mid-burst clears outputs without waiting for a clock.
        press_pulse(); idle(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  busy,        0);
        chk("arst_cnt",   click_cnt,   0);
        chk("arst_valid", click_valid, 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        nv0 = nvalid;
        idle(30);
        chk("arst_norep", nvalid - nv0, 0);

        // Randomized traffic with varying press density and occasional clears.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(3))
                0:       rate = 2;
                1:       rate = 6;
                2:       rate = 14;
                default: rate = 30;
            endcase
            repeat (50) begin
                key_n = ($urandom_range(rate - 1) != 0);
                clr   = ($urandom_range(40) == 0);
                step();
            end
        end
        key_n = 1'b1; clr = 1'b0;
        idle(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
